// File: rtl/thresh_load_seq.sv
// Threshold reload sequencer: reads one 36-bit word per beam from the threshold RAM,
// highest beam first, shifts them into the threshold cascade, then pulses update-all.
module thresh_load_seq #(
    parameter int NBEAMS    = 2,
    parameter int ADDR_BITS = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [1:0]           sel_i,
    output logic                 ram_rd_o,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    input  logic [35:0]          ram_dat_i,
    output logic [35:0]          thresh_o,
    output logic [1:0]           thresh_wr_o,
    output logic [1:0]           thresh_update_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [15:0]          load_count_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        DRAIN  = 3'd2,
        UPDATE = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NBEAMS - 1);

    state_t                 state_q;
    logic                   ram_rd_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   rd_d1_q;
    logic                   wr_v_q;
    logic [35:0]            thresh_q;
    logic [1:0]             thresh_wr_q;
    logic [1:0]             update_q;
    logic                   busy_q;
    logic                   done_q;
    logic [15:0]            load_count_q;
    logic [15:0]            load_count_d;
    logic [1:0]             sel_q;
    logic                   pend_q;
    logic [1:0]             pend_sel_q;

    assign load_count_d = load_count_q + 16'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ram_rd_q     <= 1'b0;
            addr_q       <= '0;
            rd_d1_q      <= 1'b0;
            wr_v_q       <= 1'b0;
            thresh_q     <= '0;
            thresh_wr_q  <= 2'b00;
            update_q     <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_count_q <= '0;
            sel_q        <= 2'b00;
            pend_q       <= 1'b0;
            pend_sel_q   <= 2'b00;
        end else begin
            // RAM data arrives one cycle after the strobe; register it straight into the write slot
            rd_d1_q <= ram_rd_q;
            wr_v_q  <= rd_d1_q;
            if (rd_d1_q) begin
                thresh_wr_q <= sel_q;
                thresh_q    <= (sel_q != 2'b00) ? ram_dat_i : '0;
            end else begin
                thresh_wr_q <= 2'b00;
                thresh_q    <= '0;
            end
            done_q   <= 1'b0;
            update_q <= 2'b00;

            if (start_i && (busy_q || state_q == FINISH)) begin
                pend_q     <= 1'b1;
                pend_sel_q <= sel_i;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q  <= READ;
                        ram_rd_q <= 1'b1;
                        addr_q   <= LAST_ADDR;
                        busy_q   <= 1'b1;
                        sel_q    <= sel_i;
                    end
                end
                READ: begin
                    if (addr_q == '0) begin
                        ram_rd_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        addr_q <= addr_q - 1'b1;
                    end
                end
                DRAIN: begin
                    // Last write is on the bus when the write slot is full and nothing follows it
                    if (wr_v_q && !rd_d1_q) begin
                        state_q  <= UPDATE;
                        update_q <= sel_q;
                    end
                end
                UPDATE: begin
                    state_q      <= FINISH;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    load_count_q <= load_count_d;
                end
                FINISH: begin
                    if (pend_q || start_i) begin
                        state_q  <= READ;
                        ram_rd_q <= 1'b1;
                        addr_q   <= LAST_ADDR;
                        busy_q   <= 1'b1;
                        sel_q    <= start_i ? sel_i : pend_sel_q;
                        pend_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_rd_o        = ram_rd_q;
    assign ram_addr_o      = addr_q;
    assign thresh_o        = thresh_q;
    assign thresh_wr_o     = thresh_wr_q;
    assign thresh_update_o = update_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign load_count_o    = load_count_q;

endmodule

// File: tb/tb_thresh_load_seq.sv
// Scoreboard bench for thresh_load_seq: a sequence-level model schedules expected
// reads, writes, updates and done pulses; a negedge monitor pops and compares them.
module tb_thresh_load_seq;

    localparam int NB = 2;
    localparam int AB = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    sel = 2'b00;
    logic          ram_rd_o;
    logic [AB-1:0] ram_addr_o;
    logic [35:0]   ram_dat = '0;
    logic [35:0]   thresh_o;
    logic [1:0]    thresh_wr_o;
    logic [1:0]    thresh_update_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   load_count_o;

    thresh_load_seq #(.NBEAMS(NB), .ADDR_BITS(AB)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .sel_i          (sel),
        .ram_rd_o       (ram_rd_o),
        .ram_addr_o     (ram_addr_o),
        .ram_dat_i      (ram_dat),
        .thresh_o       (thresh_o),
        .thresh_wr_o    (thresh_wr_o),
        .thresh_update_o(thresh_update_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .load_count_o   (load_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [35:0] ram [NB];
    always @(posedge clk) ram_dat <= ram_rd_o ? ram[ram_addr_o] : {4'($urandom), 32'($urandom)};

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
        logic [35:0] val;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    ev_t up_q[$];
    ev_t dn_q[$];
    bit  exp_busy[int];

    int checks = 0;
    int failures = 0;
    bit in_rst = 1'b1;

    bit         m_active = 1'b0;
    bit         m_pend = 1'b0;
    int         m_fin = 0;
    logic [1:0] m_psel = 2'b00;
    logic [15:0] m_count = 16'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
        end
    endtask

    // A sequence launched at cycle t0 occupies cycles t0+1 .. t0+NB+4
    task automatic launch(input int t0, input logic [1:0] s);
        ev_t e;
        m_active = 1'b1;
        m_fin    = t0 + NB + 4;
        m_count  = m_count + 16'd1;
        for (int k = 1; k <= NB; k++) begin
            e.cyc = t0 + k; e.sel = 2'b00; e.val = 36'(NB - k);
            rd_q.push_back(e);
            if (s != 2'b00) begin
                e.cyc = t0 + 2 + k; e.sel = s; e.val = ram[NB - k];
                wr_q.push_back(e);
            end
        end
        for (int t = t0 + 1; t <= t0 + NB + 3; t++) exp_busy[t] = 1'b1;
        if (s != 2'b00) begin
            e.cyc = t0 + NB + 3; e.sel = s; e.val = '0;
            up_q.push_back(e);
        end
        e.cyc = t0 + NB + 4; e.sel = 2'b00; e.val = 36'(m_count);
        dn_q.push_back(e);
    endtask

    task automatic advance(input int c);
        while (m_active && m_fin < c) begin
            if (m_pend) begin
                m_pend = 1'b0;
                launch(m_fin, m_psel);
            end else begin
                m_active = 1'b0;
            end
        end
    endtask

    task automatic step(input bit st, input logic [1:0] s);
        @(posedge clk);
        #1;
        start = st;
        sel   = s;
        advance(cyc);
        if (st) begin
            if (m_active) begin
                m_pend = 1'b1;
                m_psel = s;
            end else begin
                launch(cyc, s);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0; in_rst = 1'b1;
        rd_q.delete(); wr_q.delete(); up_q.delete(); dn_q.delete(); exp_busy.delete();
        m_active = 1'b0; m_pend = 1'b0; m_count = 16'd0;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0; in_rst = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (in_rst) begin
            chk("reset_outputs", {ram_rd_o, ram_addr_o, thresh_o, thresh_wr_o, thresh_update_o,
                                  busy_o, done_o, load_count_o}, '0);
        end else begin
            chk("busy", busy_o, exp_busy.exists(cyc));
            if (ram_rd_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", ram_rd_o, 1'b0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", ram_addr_o, e.val);
                end
            end
            if (thresh_wr_o != 2'b00) begin
                if (wr_q.size() == 0) chk("wr_unexpected", thresh_wr_o, 2'b00);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_sel", thresh_wr_o, e.sel);
                    chk("wr_data", thresh_o, e.val);
                end
            end else begin
                chk("thresh_idle_zero", thresh_o, '0);
            end
            if (thresh_update_o != 2'b00) begin
                chk("wr_update_overlap", thresh_wr_o, 2'b00);
                if (up_q.size() == 0) chk("update_unexpected", thresh_update_o, 2'b00);
                else begin
                    e = up_q.pop_front();
                    chk("update_cycle", cyc, e.cyc);
                    chk("update_sel", thresh_update_o, e.sel);
                end
            end
            if (done_o) begin
                if (dn_q.size() == 0) chk("done_unexpected", done_o, 1'b0);
                else begin
                    e = dn_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_count", load_count_o, e.val);
                end
            end
            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                chk("rd_missing", cyc, rd_q[0].cyc); void'(rd_q.pop_front());
            end
            if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                chk("wr_missing", cyc, wr_q[0].cyc); void'(wr_q.pop_front());
            end
            if (up_q.size() > 0 && up_q[0].cyc < cyc) begin
                chk("update_missing", cyc, up_q[0].cyc); void'(up_q.pop_front());
            end
            if (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
                chk("done_missing", cyc, dn_q[0].cyc); void'(dn_q.pop_front());
            end
        end
    end

    initial begin
        ram[1] = 36'h00001_00002;
        ram[0] = 36'h00003_00004;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_rst = 1'b0;
        idle(2);

        step(1'b1, 2'b11);
        idle(10);
        chk("count_after_first", load_count_o, 16'd1);

        step(1'b1, 2'b01);
        idle(10);

        step(1'b1, 2'b11); step(1'b0, 2'b00);
        step(1'b1, 2'b10); step(1'b0, 2'b00);
        step(1'b1, 2'b10);
        idle(16);

        step(1'b1, 2'b00);
        idle(10);

        step(1'b1, 2'b01);
        idle(NB + 3);
        step(1'b1, 2'b10);
        idle(16);

        step(1'b1, 2'b11); step(1'b0, 2'b00); step(1'b0, 2'b00);
        do_reset(2);
        chk("count_after_abort", load_count_o, 16'd0);
        step(1'b1, 2'b11);
        idle(10);

        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < NB; b++) ram[b] = {4'($urandom), 32'($urandom)};
            for (int i = 0; i < 60; i++) step($urandom_range(0, 3) == 0, 2'($urandom));
            idle(16);
        end

        @(negedge clk);
        force dut.load_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.load_count_q;
        m_count = 16'hFFFF;
        step(1'b1, 2'b11);
        idle(10);
        chk("count_wrapped", load_count_o, 16'h0000);

        idle(3);
        chk("queues_drained", 64'(rd_q.size() + wr_q.size() + up_q.size() + dn_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
